// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequencer that decodes an ALU request, drives operands and
// control onto an external combinational 32-bit ALU, waits SETTLE_CYCLES,
// then captures the result and presents it on a valid/ready response port.
//
// Optional feature macro: ALU_ILLEGAL_TRAP_EN
//   defined   : an unknown R-type funct bypasses EXEC and returns a trapped
//               response (rsp_illegal=1, rsp_result=0, rsp_zero=1) one cycle
//               after acceptance.
//   undefined : an unknown funct decodes as ADD; rsp_illegal is tied to 0.
//
// FSM states
//   state   | meaning
//   IDLE    | req_ready=1, waiting for req_valid
//   EXEC    | operands/control held on the ALU, settle counter running
//   RESP    | rsp_valid=1, response held until rsp_ready

module alu_ctrl_seq #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_alu_op,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal
);

    // Counter is loaded with SETTLE_CYCLES-1 at acceptance so that the
    // capture edge lands exactly SETTLE_CYCLES edges after acceptance.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic [3:0]  r_alu_control;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic        r_rsp_illegal;
    logic        w_dec_illegal;
`endif
    logic [3:0]  w_dec_ctrl;

    // Decode the request's alu_op/funct into the 4-bit ALU control code.
    always_comb begin
        w_dec_ctrl = CTL_ADD;
`ifdef ALU_ILLEGAL_TRAP_EN
        w_dec_illegal = 1'b0;
`endif
        case (req_alu_op)
            2'b00: w_dec_ctrl = CTL_ADD;
            2'b01: w_dec_ctrl = CTL_SUB;
            2'b11: w_dec_ctrl = CTL_OR;
            default: begin
                case (req_funct)
                    6'b100100: w_dec_ctrl = CTL_AND;
                    6'b100101: w_dec_ctrl = CTL_OR;
                    6'b100000: w_dec_ctrl = CTL_ADD;
                    6'b100010: w_dec_ctrl = CTL_SUB;
                    6'b101010: w_dec_ctrl = CTL_SLT;
                    6'b100111: w_dec_ctrl = CTL_NOR;
                    default: begin
                        // Unknown funct falls back to ADD; flagged only when trapping.
                        w_dec_ctrl = CTL_ADD;
`ifdef ALU_ILLEGAL_TRAP_EN
                        w_dec_illegal = 1'b1;
`endif
                    end
                endcase
            end
        endcase
    end

    // Control FSM with registered handshake, ALU drive and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_req_ready   <= 1'b1;
            r_alu_control <= 4'b0000;
            r_alu_a       <= 32'd0;
            r_alu_b       <= 32'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= 32'd0;
            r_rsp_zero    <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
            r_rsp_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_alu_a     <= req_a;
                        r_alu_b     <= req_b;
                        r_req_ready <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
                        if (w_dec_illegal) begin
                            // Trapped request never touches the ALU result.
                            r_alu_control <= 4'b0000;
                            r_rsp_result  <= 32'd0;
                            r_rsp_zero    <= 1'b1;
                            r_rsp_illegal <= 1'b1;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            r_alu_control <= w_dec_ctrl;
                            r_cnt         <= CNT_LOAD;
                            r_state       <= ST_EXEC;
                        end
`else
                        r_alu_control <= w_dec_ctrl;
                        r_cnt         <= CNT_LOAD;
                        r_state       <= ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_result <= alu_result;
                        r_rsp_zero   <= (alu_result == 32'd0);
`ifdef ALU_ILLEGAL_TRAP_EN
                        r_rsp_illegal <= 1'b0;
`endif
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign alu_control = r_alu_control;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
`ifdef ALU_ILLEGAL_TRAP_EN
    assign rsp_illegal = r_rsp_illegal;
`else
    assign rsp_illegal = 1'b0;
`endif

endmodule
